multi_waveform_generator: RTL and testbench
===========================================

# multi_waveform_generator

Parametrised multi-channel waveform source that produces DAC codes for the SPI DAC driver path. One shared prescaler sets the sample rate. Each channel has its own phase accumulator and tuning step, so channels can run at independent frequencies. Each channel shapes its phase into saw-up, saw-down, triangle or square output, with optional inversion. This block replaces the fixed 12-bit sawtooth counter that feeds the DAC driver's Va/Vb inputs.

## Interface
Parameters:
- NCH, 2, number of output channels
- DATA_W, 12, output code width per channel
- ACC_W, 16, phase accumulator width; must be ≥ DATA_W+1
- DIV_W, 30, prescaler period width

Ports:
- CLK_50M  in  1  system clock; one clock domain only
- RST_N  in  1  reset, asynchronous, active-low
- ENABLE  in  1  run enable; when low, the prescaler is held at 0 and no ticks occur
- PERIOD  in  DIV_W  sample period in clocks; the value 0 behaves as 1
- PHASE_RST  in  1  synchronous clear of the prescaler and all accumulators
- STEP  in  NCH*ACC_W  per-channel tuning word; channel k uses bits [k*ACC_W +: ACC_W]
- MODE  in  NCH*2  per-channel shape: 0 SAW_UP, 1 SAW_DOWN, 2 TRIANGLE, 3 SQUARE
- INVERT  in  NCH  per-channel bitwise inversion of the shaped code
- DUTY  in  NCH*DATA_W  per-channel square threshold; present only with WAVEGEN_DUTY_EN
- SAMPLE_OUT  out  NCH*DATA_W  registered DAC codes
- SAMPLE_VALID  out  1  one-cycle pulse on each cycle where SAMPLE_OUT updates

## Operation
- Prescaler: counts 0..PERIOD-1 while ENABLE is high.
  - A tick is asserted in the cycle where count == PERIOD-1 (or every cycle if PERIOD ≤ 1); the count then returns to 0.
  - If PERIOD is reduced below the current count, the counter wraps at the next compare (≥ comparison).
- On a tick, each channel does:
  - acc ← acc + STEP, modulo 2^ACC_W.
  - SAMPLE_OUT ← shape(acc+STEP), computed from the new phase in the same edge.
- Shaping: top = acc[ACC_W-1 -: DATA_W], msb = acc[ACC_W-1], t = acc[ACC_W-2 -: DATA_W].
  - SAW_UP: top.
  - SAW_DOWN: ~top.
  - TRIANGLE: msb ? ~t : t.
  - SQUARE: all-ones when top < DUTY, else 0.
  - Then XOR with INVERT replicated to DATA_W bits.
- MODE, STEP, INVERT and DUTY are sampled only on a tick. Changing them never disturbs the accumulator.
- PHASE_RST has priority over a tick in the same cycle:
  - prescaler ← 0, all acc ← 0;
  - SAMPLE_OUT holds its value;
  - SAMPLE_VALID stays 0 that cycle.
- Deasserting ENABLE freezes acc and SAMPLE_OUT; counting resumes from prescaler count 0.

## Timing
- Reset (RST_N low, asynchronous): prescaler 0, all acc 0, SAMPLE_OUT 0, SAMPLE_VALID 0. Release is synchronous to the next CLK_50M edge.
- Latency: a tick in cycle n produces SAMPLE_OUT and SAMPLE_VALID=1 visible in cycle n+1. SAMPLE_VALID returns to 0 in n+2 unless another tick occurred.
- With PERIOD = P ≥ 1, SAMPLE_VALID has period exactly P clocks. The first pulse is P clocks after ENABLE rises or after PHASE_RST.
- Output frequency = 50 MHz / (P · 2^ACC_W / STEP). STEP = 0 gives a constant output.
- Wrap: the accumulator overflows silently. There is no carry output.

## Configuration
- WAVEGEN_DUTY_EN defined: the DUTY port exists and sets the square threshold per channel.
- WAVEGEN_DUTY_EN undefined: the DUTY port is absent and the threshold is fixed at 2^(DATA_W-1), giving a 50 % square that is high during the first half-phase.

## Structure
- Package wavegen_pkg holds:
  - the MODE code localparams (MODE_SAW_UP = 2'd0 … MODE_SQUARE = 2'd3);
  - a mode_t typedef;
  - the shaping function.
- Sub-module wavegen_channel: holds one accumulator plus the shaper and output register, driven by the shared tick.
- The top level contains the prescaler, the SAMPLE_VALID register and a generate loop of NCH wavegen_channel instances.

## Test plan
All scenarios use DATA_W=12, ACC_W=16, NCH=2.
1. Async reset: pull RST_N low between clock edges mid-run -> SAMPLE_OUT = 0 and SAMPLE_VALID = 0 immediately, without waiting for a clock edge.
2. PERIOD=4, STEP=0x0010, SAW_UP -> SAMPLE_VALID every 4 clocks; codes 0x001, 0x002, 0x003…; the 4096th tick returns 0x000.
3. PERIOD=1, STEP=0x0100, TRIANGLE -> after tick 127 the code is 0xFE0; tick 128 gives 0xFFF; tick 255 gives 0x01F.
4. STEP=0x4000, SQUARE, default duty -> tick sequence 0xFFF, 0x000, 0x000, 0xFFF, repeating.
5. Assert PHASE_RST in the same cycle as a tick -> no SAMPLE_VALID pulse and SAMPLE_OUT unchanged; the next tick yields shape(STEP).
6. Ch0 SAW_UP and ch1 SAW_DOWN with INVERT=1, both at STEP=0x0040 -> both channels are equal on every sample.

Source files
------------

// File: rtl/wavegen_pkg.sv
// wavegen_pkg: shared definitions for the multi-channel waveform generator.
// Holds the MODE codes, the mode_t type and the phase-to-code shaping function.
package wavegen_pkg;

    localparam logic [1:0] MODE_SAW_UP   = 2'd0;
    localparam logic [1:0] MODE_SAW_DOWN = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;
    localparam logic [1:0] MODE_SQUARE   = 2'd3;

    typedef enum logic [1:0] {
        SHAPE_SAW_UP   = MODE_SAW_UP,
        SHAPE_SAW_DOWN = MODE_SAW_DOWN,
        SHAPE_TRIANGLE = MODE_TRIANGLE,
        SHAPE_SQUARE   = MODE_SQUARE
    } mode_t;

    // Widest code the shaper handles; callers truncate to their DATA_W.
    localparam int unsigned SHAPE_W = 32;

    // Shape one phase into a DAC code. 'mask' has the low DATA_W bits set so
    // the bitwise complements stay inside the channel's code width.
    function automatic logic [SHAPE_W-1:0] shape(
        input mode_t              mode,
        input logic [SHAPE_W-1:0] top,
        input logic [SHAPE_W-1:0] t,
        input logic               msb,
        input logic [SHAPE_W-1:0] duty,
        input logic               inv,
        input logic [SHAPE_W-1:0] mask
    );
        logic [SHAPE_W-1:0] code;
        code = '0;
        case (mode)
            SHAPE_SAW_UP:   code = top;
            SHAPE_SAW_DOWN: code = ~top & mask;
            SHAPE_TRIANGLE: code = msb ? (~t & mask) : t;
            SHAPE_SQUARE:   code = (top < duty) ? mask : '0;
            default:        code = '0;
        endcase
        return code ^ ({SHAPE_W{inv}} & mask);
    endfunction

endpackage

// File: rtl/wavegen_channel.sv
// wavegen_channel: one phase accumulator plus shaper and registered output code.
// Ports: clk/rst_n, shared tick and phase_rst, per-channel step/mode/invert/duty,
// registered sample code out.
module wavegen_channel
    import wavegen_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  logic              i_phase_rst,
    input  logic [ACC_W-1:0]  i_step,
    input  mode_t             i_mode,
    input  logic              i_invert,
    input  logic [DATA_W-1:0] i_duty,
    output logic [DATA_W-1:0] o_sample
);

    localparam logic [SHAPE_W-1:0] MASK = SHAPE_W'({DATA_W{1'b1}});

    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_sample;
    logic [ACC_W-1:0]  w_acc_next;
    logic [DATA_W-1:0] w_top;
    logic [DATA_W-1:0] w_t;
    logic [DATA_W-1:0] w_code;

    // The output is shaped from the new phase, not the one being replaced.
    assign w_acc_next = r_acc + i_step;
    assign w_top      = w_acc_next[ACC_W-1 -: DATA_W];
    assign w_t        = w_acc_next[ACC_W-2 -: DATA_W];
    assign w_code     = DATA_W'(shape(i_mode, SHAPE_W'(w_top), SHAPE_W'(w_t),
                                      w_acc_next[ACC_W-1], SHAPE_W'(i_duty),
                                      i_invert, MASK));

    // Phase clear wins over a tick and leaves the last code on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_sample <= '0;
        end else if (i_phase_rst) begin
            r_acc    <= '0;
        end else if (i_tick) begin
            r_acc    <= w_acc_next;
            r_sample <= w_code;
        end
    end

    assign o_sample = r_sample;

endmodule

// File: rtl/multi_waveform_generator.sv
// multi_waveform_generator: NCH-channel DDS waveform source feeding the DAC driver.
// A shared prescaler produces a sample tick every PERIOD clocks; each channel
// advances its own phase accumulator and shapes it into a DAC code.
// Ports: CLK_50M, RST_N (async active-low), ENABLE, PERIOD, PHASE_RST, STEP,
// MODE, INVERT, DUTY (only with WAVEGEN_DUTY_EN), SAMPLE_OUT, SAMPLE_VALID.
// Config macro WAVEGEN_DUTY_EN: adds the per-channel DUTY threshold port;
// otherwise the square threshold is fixed at half scale.
module multi_waveform_generator
    import wavegen_pkg::*;
#(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned DIV_W  = 30
) (
    input  logic                  CLK_50M,
    input  logic                  RST_N,
    input  logic                  ENABLE,
    input  logic [DIV_W-1:0]      PERIOD,
    input  logic                  PHASE_RST,
    input  logic [NCH*ACC_W-1:0]  STEP,
    input  logic [NCH*2-1:0]      MODE,
    input  logic [NCH-1:0]        INVERT,
`ifdef WAVEGEN_DUTY_EN
    input  logic [NCH*DATA_W-1:0] DUTY,
`endif
    output logic [NCH*DATA_W-1:0] SAMPLE_OUT,
    output logic                  SAMPLE_VALID
);

    localparam logic [DATA_W-1:0] DUTY_HALF = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DIV_W-1:0] r_cnt;
    logic             r_valid;
    logic             w_tick;

    // Periods 0 and 1 tick every cycle; >= lets a shrunken PERIOD wrap at once.
    assign w_tick = ENABLE &&
                    ((PERIOD <= DIV_W'(1)) || (r_cnt >= (PERIOD - DIV_W'(1))));

    // Prescaler: restarts from 0 after a tick, a phase clear or while disabled.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_tick && !PHASE_RST;
            if (PHASE_RST || !ENABLE || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

    assign SAMPLE_VALID = r_valid;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DATA_W-1:0] w_duty;
`ifdef WAVEGEN_DUTY_EN
        assign w_duty = DUTY[k*DATA_W +: DATA_W];
`else
        assign w_duty = DUTY_HALF;
`endif
        wavegen_channel #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_ch (
            .clk         (CLK_50M),
            .rst_n       (RST_N),
            .i_tick      (w_tick),
            .i_phase_rst (PHASE_RST),
            .i_step      (STEP[k*ACC_W +: ACC_W]),
            .i_mode      (mode_t'(MODE[k*2 +: 2])),
            .i_invert    (INVERT[k]),
            .i_duty      (w_duty),
            .o_sample    (SAMPLE_OUT[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_multi_waveform_generator.sv
// Directed self-checking bench for multi_waveform_generator (NCH=2, DATA_W=12, ACC_W=16).
module tb_multi_waveform_generator;

    localparam int unsigned NCH    = 2;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned DIV_W  = 30;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic [DIV_W-1:0]      period;
    logic                  phase_rst;
    logic [NCH*ACC_W-1:0]  step;
    logic [NCH*2-1:0]      mode;
    logic [NCH-1:0]        invert;
`ifdef WAVEGEN_DUTY_EN
    logic [NCH*DATA_W-1:0] duty;
`endif
    logic [NCH*DATA_W-1:0] sample_out;
    logic                  sample_valid;

    int n_asserts = 0;
    int n_fail    = 0;

    always #10 clk = ~clk;

    multi_waveform_generator #(
        .NCH(NCH), .DATA_W(DATA_W), .ACC_W(ACC_W), .DIV_W(DIV_W)
    ) dut (
        .CLK_50M      (clk),
        .RST_N        (rst_n),
        .ENABLE       (enable),
        .PERIOD       (period),
        .PHASE_RST    (phase_rst),
        .STEP         (step),
        .MODE         (mode),
        .INVERT       (invert),
`ifdef WAVEGEN_DUTY_EN
        .DUTY         (duty),
`endif
        .SAMPLE_OUT   (sample_out),
        .SAMPLE_VALID (sample_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step clocks until SAMPLE_VALID is seen (sampled 1 ns after each edge).
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sample_valid && n < limit);
        check("valid_timeout", 32'(sample_valid), 32'd1);
    endtask

    function automatic logic [31:0] ch(input int k);
        return 32'(sample_out[k*DATA_W +: DATA_W]);
    endfunction

    initial begin
        int n;
        logic [11:0] sq [4];
        sq[0] = 12'hFFF; sq[1] = 12'h000; sq[2] = 12'h000; sq[3] = 12'hFFF;

        rst_n     = 1'b0;
        enable    = 1'b0;
        period    = 30'd4;
        phase_rst = 1'b0;
        step      = '0;
        mode      = '0;
        invert    = '0;
`ifdef WAVEGEN_DUTY_EN
        duty      = {12'h800, 12'h800};
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(sample_out), 32'd0);
        check("reset_valid", 32'(sample_valid), 32'd0);

        // Saw-up at PERIOD=4: pulse every 4 clocks, ch0 counts by 1, ch1 by 2
        rst_n  = 1'b1;
        enable = 1'b1;
        step   = {16'h0020, 16'h0010};
        mode   = 4'b00_00;
        for (int i = 1; i <= 4099; i++) begin
            wait_valid(10, n);
            check("saw_period", 32'(n), 32'd4);
            check("saw_ch0", ch(0), 32'(i % 4096));
            check("saw_ch1", ch(1), 32'((2 * i) % 4096));
        end

        // Asynchronous reset between edges while a pulse is showing
        #4;
        rst_n = 1'b0;
        #1;
        check("async_out", 32'(sample_out), 32'd0);
        check("async_valid", 32'(sample_valid), 32'd0);

        // Triangle on ch0, saw-down on ch1, PERIOD=1
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        period = 30'd1;
        step   = {16'h0100, 16'h0100};
        mode   = 4'b01_10;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk);
            #1;
            check("tri_valid", 32'(sample_valid), 32'd1);
            if (i == 1) begin
                check("tri_ch0_1", ch(0), 32'h020);
                check("sd_ch1_1", ch(1), 32'hFEF);
            end
            if (i == 127) begin
                check("tri_ch0_127", ch(0), 32'hFE0);
                check("sd_ch1_127", ch(1), 32'h80F);
            end
            if (i == 128) begin
                check("tri_ch0_128", ch(0), 32'hFFF);
                check("sd_ch1_128", ch(1), 32'h7FF);
            end
            if (i == 255) begin
                check("tri_ch0_255", ch(0), 32'h01F);
                check("sd_ch1_255", ch(1), 32'h00F);
            end
        end

        // Phase clear with new config: output held, no pulse
        phase_rst = 1'b1;
        mode      = 4'b11_11;
        step      = {16'h4000, 16'h4000};
        invert    = 2'b10;
        @(posedge clk);
        #1;
        check("prst_valid", 32'(sample_valid), 32'd0);
        check("prst_ch0_hold", ch(0), 32'h000);
        check("prst_ch1_hold", ch(1), 32'hFFF);
        phase_rst = 1'b0;

        // Square at default duty, ch1 inverted
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            check("sq_valid", 32'(sample_valid), 32'd1);
            check("sq_ch0", ch(0), 32'(sq[(i - 1) % 4]));
            check("sq_ch1", ch(1), 32'(sq[(i - 1) % 4] ^ 12'hFFF));
        end

        // Phase clear landing exactly on a tick at PERIOD=4
        period    = 30'd4;
        mode      = 4'b00_00;
        step      = {16'h0030, 16'h0010};
        invert    = 2'b00;
        phase_rst = 1'b1;
        @(posedge clk);
        #1;
        phase_rst = 1'b0;
        wait_valid(10, n);
        check("prt_first_period", 32'(n), 32'd4);
        check("prt_ch0_a", ch(0), 32'h001);
        check("prt_ch1_a", ch(1), 32'h003);
        repeat (3) @(posedge clk);
        #1;
        check("prt_gap_valid", 32'(sample_valid), 32'd0);
        phase_rst = 1'b1;
        @(posedge clk);
        #1;
        check("prt_tick_valid", 32'(sample_valid), 32'd0);
        check("prt_tick_ch0", ch(0), 32'h001);
        check("prt_tick_ch1", ch(1), 32'h003);
        phase_rst = 1'b0;
        wait_valid(10, n);
        check("prt_after_period", 32'(n), 32'd4);
        check("prt_ch0_b", ch(0), 32'h001);
        check("prt_ch1_b", ch(1), 32'h003);

        // Saw-up vs inverted saw-down: identical codes
        phase_rst = 1'b1;
        step      = {16'h0040, 16'h0040};
        mode      = 4'b01_00;
        invert    = 2'b10;
        @(posedge clk);
        #1;
        check("pair_prst_valid", 32'(sample_valid), 32'd0);
        phase_rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            wait_valid(10, n);
            check("pair_period", 32'(n), 32'd4);
            check("pair_ch0", ch(0), 32'(4 * i));
            check("pair_ch1", ch(1), 32'(4 * i));
        end

        // Disable freezes output; restart takes a full period
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("freeze_valid", 32'(sample_valid), 32'd0);
        check("freeze_ch0", ch(0), 32'd80);
        check("freeze_ch1", ch(1), 32'd80);
        enable = 1'b1;
        wait_valid(10, n);
        check("resume_period", 32'(n), 32'd4);
        check("resume_ch0", ch(0), 32'd84);
        check("resume_ch1", ch(1), 32'd84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
